param_alu_display: RTL and testbench



---
 rtl/param_alu_pkg.sv | 23 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/param_alu_display.sv | 158 +++++++++++++++
 tb/tb_param_alu_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/param_alu_pkg.sv
// Shared definitions for the ALU/display block: opcodes, FSM state, hex glyphs.
package param_alu_pkg;

  localparam logic [2:0] OP_SUB = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Active-low segments {a,b,c,d,e,f,g}; ascending index so GLYPH[n] is digit n.
  localparam logic [0:15][6:0] GLYPH = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decode
  import param_alu_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH[hex];

endmodule

// File: rtl/param_alu_display.sv
// Handshaked ALU with bit-serial shifter; last result is held in a display
// register and scanned out over a multiplexed 7-segment display.
module param_alu_display
  import param_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SCAN_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   rd,
  output logic               carry,
  output logic               zero,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] an
);

  localparam int DIGITS = WIDTH / 4;
  localparam int SHW    = $clog2(WIDTH);
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       work, work_sh, disp;
  logic [SHW-1:0]         cnt;
  logic                   is_sra;
  logic [SCAN_BITS-1:0]   scan;

  logic [WIDTH:0]         add_w, sub_w;
  logic [WIDTH-1:0]       alu_rd, res;
  logic                   alu_c, res_c;
  logic                   is_shift, accept, load_res, load_shift;
  logic [SHW-1:0]         n_sh;

  // ---- single-cycle ALU; bit WIDTH of sub_w is the unsigned borrow
  assign add_w    = {1'b0, rs} + {1'b0, rt};
  assign sub_w    = {1'b0, rs} - {1'b0, rt};
  assign n_sh     = rs[SHW-1:0];
  assign is_shift = (sel == OP_SRA) || (sel == OP_SLL);

  always_comb begin
    alu_rd = rt;
    alu_c  = 1'b0;
    case (sel)
      OP_SUB: begin alu_rd = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
      OP_ADD: begin alu_rd = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      OP_OR:  alu_rd = rs | rt;
      OP_AND: alu_rd = rs & rt;
      OP_LT:  alu_rd = {{(WIDTH-1){1'b0}}, (rs < rt)};
      OP_EQ:  alu_rd = {{(WIDTH-1){1'b0}}, (rs == rt)};
      default: alu_rd = rt;  // zero-distance shift passes rt through
    endcase
  end

  assign work_sh = is_sra ? {work[WIDTH-1], work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};

  // ---- control FSM
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    load_res   = 1'b0;
    load_shift = 1'b0;
    res        = alu_rd;
    res_c      = alu_c;
    case (state)
      IDLE: if (accept) begin
        if (is_shift && (n_sh != '0)) begin
          load_shift = 1'b1;
          state_nxt  = SHIFT;
        end else begin
          load_res  = 1'b1;
          state_nxt = DONE;
        end
      end
      SHIFT: if (cnt == SHW'(1)) begin
        load_res  = 1'b1;
        res       = work_sh;
        res_c     = 1'b0;
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      is_sra <= 1'b0;
      rd     <= '0;
      carry  <= 1'b0;
      disp   <= '0;
    end else begin
      if (load_shift) begin
        work   <= rt;
        cnt    <= n_sh;
        is_sra <= (sel == OP_SRA);
      end else if (state == SHIFT) begin
        work <= work_sh;
        cnt  <= cnt - SHW'(1);
      end
      if (load_res) begin
        rd    <= res;
        carry <= res_c;
        disp  <= res;
      end
    end
  end

  assign zero = (rd == '0);

  // ---- display scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan <= '0;
    else        scan <= scan + SCAN_BITS'(1);
  end

  logic [IDXW-1:0] dig;
  logic [3:0]      nib;

  if (DIGITS == 1) begin : g_one_digit
    assign dig = '0;
  end else begin : g_multi_digit
    assign dig = IDXW'(int'(scan[SCAN_BITS-1 -: IDXW]) % DIGITS);
  end

  always_comb begin
    an  = '1;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(dig) == i) begin
        an[i] = 1'b0;
        nib   = disp[4*i +: 4];
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex (nib),
    .seg (seg)
  );

endmodule

// File: tb/tb_param_alu_display.sv
// Directed scoreboard bench: stimulus pushes expected results, a forked
// monitor pops and compares on each rising out_valid.
module tb_param_alu_display;

  localparam logic [2:0] SUB = 3'd0, ADD = 3'd1, OR_ = 3'd2, AND_ = 3'd3,
                         SRA = 3'd4, SLL = 3'd5, LT = 3'd6, EQ = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] sel = 3'd0;
  logic [7:0] rs = 8'h00, rt = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] rd;
  logic       carry, zero;
  logic [6:0] seg;
  logic [1:0] an;

  param_alu_display #(.WIDTH(8), .SCAN_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .rs(rs), .rt(rt), .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .carry(carry), .zero(zero), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] gl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [7:0] rd;
    logic       c;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // lat = shift cycles between the accept edge and out_valid (0 for single-cycle ops)
  task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ec, input int lat, input bit expect_res);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin timeout("in_ready_wait"); return; end
    in_valid = 1'b1; sel = s; rs = a; rt = b;
    if (expect_res) sb.push_back('{rd: er, c: ec, z: (er == 8'h00), lat: lat, acc: cyc + 1});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    logic prev_ov = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_result: got rd=%0h with nothing outstanding", rd);
        end else begin
          e = sb.pop_front();
          chk("rd", 32'(rd), 32'(e.rd));
          chk("carry", 32'(carry), 32'(e.c));
          chk("zero", 32'(zero), 32'(e.z));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  endtask

  initial begin
    bit seen0, seen1;
    int t;
    fork monitor(); join_none

    // reset behaviour
    #2;
    chk("rst_an", 32'(an), 32'(2'b10));
    chk("rst_seg", 32'(seg), 32'(7'b0000001));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_an", 32'(an) == 32'(2'b10) || 32'(an) == 32'(2'b01) ? 32'(seg) : 32'hbad, 32'(7'b0000001));
    chk("init_in_ready", 32'(in_ready), 32'(1));
    chk("init_out_valid", 32'(out_valid), 32'(0));
    chk("init_zero", 32'(zero), 32'(1));
    chk("init_rd", 32'(rd), 32'(0));

    // held result with in_valid asserted during DONE
    out_ready = 1'b0;
    issue(ADD, 8'hF0, 8'h25, 8'h15, 1'b1, 0, 1'b1);
    in_valid = 1'b1; sel = ADD; rs = 8'h01; rt = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'(1));
      chk("hold_rd", 32'(rd), 32'(8'h15));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_out_valid", 32'(out_valid), 32'(0));
    chk("pop_in_ready", 32'(in_ready), 32'(1));

    // display keeps showing 0x15 across scan wraps
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an == 2'b10) begin seen0 = 1; chk("disp_dig0", 32'(seg), 32'(gl[5])); end
      else if (an == 2'b01) begin seen1 = 1; chk("disp_dig1", 32'(seg), 32'(gl[1])); end
      else chk("disp_an_onehot", 32'(an), 32'(2'b10));
    end
    chk("disp_both_digits", 32'({seen1, seen0}), 32'(2'b11));

    issue(SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 0, 1'b1);
    issue(SLL, 8'h03, 8'h81, 8'h08, 1'b0, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("shift_in_ready", 32'(in_ready), 32'(0));
      chk("shift_out_valid", 32'(out_valid), 32'(0));
      if (i < 2) @(negedge clk);
    end
    issue(SRA, 8'h02, 8'h90, 8'hE4, 1'b0, 2, 1'b1);
    issue(SRA, 8'h00, 8'h90, 8'h90, 1'b0, 0, 1'b1);
    issue(LT,  8'h03, 8'h05, 8'h01, 1'b0, 0, 1'b1);
    issue(EQ,  8'h07, 8'h07, 8'h01, 1'b0, 0, 1'b1);
    issue(EQ,  8'h07, 8'h06, 8'h00, 1'b0, 0, 1'b1);
    issue(OR_, 8'hA5, 8'h0F, 8'hAF, 1'b0, 0, 1'b1);
    issue(ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b1);
    issue(SUB, 8'h05, 8'h03, 8'h02, 1'b0, 0, 1'b1);
    issue(SLL, 8'h0F, 8'h01, 8'h80, 1'b0, 7, 1'b1);  // only rs[2:0] sets distance
    issue(SRA, 8'h07, 8'h7F, 8'h00, 1'b0, 7, 1'b1);
    issue(AND_, 8'hA5, 8'h0F, 8'h05, 1'b0, 0, 1'b1);

    // reset during a long shift abandons it
    issue(SLL, 8'h05, 8'h01, 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rd", 32'(rd), 32'(0));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_seg", 32'(seg), 32'(7'b0000001));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'(0));
    end
    issue(ADD, 8'h01, 8'h01, 8'h02, 1'b0, 0, 1'b1);

    t = 0;
    while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (sb.size() != 0) timeout("scoreboard_drain");
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
